// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS: stalls, flushes, memory freeze and HALT handling.
// Optional HAZ_PERF_CNT_EN adds stall_count / flush_count performance counters.
module hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_halt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              resume,
`ifdef HAZ_PERF_CNT_EN
    output logic [31:0]       stall_count,
    output logic [31:0]       flush_count,
`endif
    output logic              pc_we,
    output logic              if_id_le,
    output logic              if_id_clear,
    output logic              id_ex_bubble,
    output logic              back_le,
    output logic              halted,
    output logic              mem_timeout
);
    typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT, HALTED} state_t;

    localparam logic [3:0]  FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TO_M1      = 16'(MEM_TIMEOUT - 1);

    state_t      state, ret_state, eff_state, nxt_state;
    logic [3:0]  flush_cnt, nxt_flush;
    logic [15:0] busy_cnt;
    logic        to_reg;
    logic        load_use;

    assign load_use = ex_memread && (ex_rt != '0) &&
                      ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

    // Leaving MEMWAIT, the cycle behaves as the state that was interrupted.
    assign eff_state = (state == MEMWAIT) ? ret_state : state;

    always_comb begin
        pc_we        = 1'b1;
        if_id_le     = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_bubble = 1'b0;
        back_le      = 1'b1;
        nxt_state    = eff_state;
        nxt_flush    = flush_cnt;
        if (mem_busy) begin
            pc_we     = 1'b0;
            if_id_le  = 1'b0;
            back_le   = 1'b0;
            nxt_state = MEMWAIT;
        end else begin
            case (eff_state)
                HALTED: begin
                    pc_we        = 1'b0;
                    if_id_le     = 1'b0;
                    id_ex_bubble = 1'b1;
                    nxt_state    = resume ? RUN : HALTED;
                end
                FLUSH: begin
                    if_id_clear = 1'b1;
                    if (branch_taken) begin
                        nxt_flush = FLUSH_INIT;
                        nxt_state = (FLUSH_INIT != '0) ? FLUSH : RUN;
                    end else begin
                        nxt_flush = (flush_cnt == '0) ? '0 : flush_cnt - 4'd1;
                        nxt_state = (flush_cnt <= 4'd1) ? RUN : FLUSH;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        if_id_clear = 1'b1;
                        nxt_flush   = FLUSH_INIT;
                        nxt_state   = (FLUSH_INIT != '0) ? FLUSH : RUN;
                    end else if (load_use) begin
                        pc_we        = 1'b0;
                        if_id_le     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end else if (id_halt) begin
                        nxt_state = HALTED;
                    end
                end
            endcase
        end
        if (!reset) begin
            pc_we        = 1'b0;
            if_id_le     = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_bubble = 1'b1;
            back_le      = 1'b0;
        end
    end

    assign halted      = reset && (state == HALTED);
    // Timeout is visible in the same cycle the counter reaches the limit.
    assign mem_timeout = reset && (to_reg || (mem_busy && busy_cnt == TO_M1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            ret_state <= RUN;
            flush_cnt <= '0;
            busy_cnt  <= '0;
            to_reg    <= 1'b0;
        end else begin
            state     <= nxt_state;
            flush_cnt <= nxt_flush;
            if (mem_busy) begin
                if (state != MEMWAIT) ret_state <= state;
                if (busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
                if (busy_cnt == TO_M1) to_reg <= 1'b1;
            end else begin
                busy_cnt <= '0;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_we)      stall_count <= stall_count + 32'd1;
            if (if_id_clear) flush_count <= flush_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: table of single-cycle load-use vectors plus
// hand-written branch/flush, memory-wait, timeout and halt/reset sequences.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_halt, ex_memread;
    logic       branch_taken, mem_busy, resume;
    logic       pc_we, if_id_le, if_id_clear, id_ex_bubble, back_le, halted, mem_timeout;
    int         n_chk = 0;
    int         n_fail = 0;

    // Expected vector order: {pc_we, if_id_le, if_id_clear, id_ex_bubble, back_le, halted, mem_timeout}
    localparam logic [6:0] E_RST   = 7'b0011000;
    localparam logic [6:0] E_NORM  = 7'b1100100;
    localparam logic [6:0] E_STALL = 7'b0001100;
    localparam logic [6:0] E_FLUSH = 7'b1110100;
    localparam logic [6:0] E_FREEZ = 7'b0000000;
    localparam logic [6:0] E_HALT  = 7'b0001110;

    hazard_ctrl #(.REG_AW(5), .FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .resume(resume), .pc_we(pc_we), .if_id_le(if_id_le),
        .if_id_clear(if_id_clear), .id_ex_bubble(id_ex_bubble), .back_le(back_le),
        .halted(halted), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt, exrt;
        logic       urs, urt, mrd;
        logic [6:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [6:0] exp);
        logic [6:0] act;
        act = {pc_we, if_id_le, if_id_clear, id_ex_bubble, back_le, halted, mem_timeout};
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_halt = 1'b0; ex_memread = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; resume = 1'b0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic next();
        @(negedge clk);
        idle();
    endtask

    initial begin
        tbl[0] = '{5'd8,  5'd0,  5'd8,  1'b1, 1'b0, 1'b1, E_STALL, "lu_rs"};
        tbl[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, E_NORM,  "lu_rt0"};
        tbl[2] = '{5'd8,  5'd0,  5'd8,  1'b0, 1'b0, 1'b1, E_NORM,  "lu_nouse_rs"};
        tbl[3] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b1, 1'b1, E_STALL, "lu_rt"};
        tbl[4] = '{5'd1,  5'd5,  5'd5,  1'b1, 1'b0, 1'b1, E_NORM,  "lu_nouse_rt"};
        tbl[5] = '{5'd8,  5'd0,  5'd8,  1'b1, 1'b0, 1'b0, E_NORM,  "no_load"};
        tbl[6] = '{5'd3,  5'd4,  5'd9,  1'b1, 1'b1, 1'b1, E_NORM,  "lu_miss"};
        tbl[7] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, E_STALL, "lu_r31"};

        idle();
        reset = 1'b0;
        #12 chk("reset", E_RST);
        next(); reset = 1'b1;
        #1 chk("first_run", E_NORM);

        foreach (tbl[i]) begin
            next();
            id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_rt = tbl[i].exrt;
            id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; ex_memread = tbl[i].mrd;
            #1 chk(tbl[i].name, tbl[i].exp);
        end

        // Two-cycle flush after a branch, load-use suppressed while clearing.
        next(); branch_taken = 1'b1;
        #1 chk("br_cyc1", E_FLUSH);
        next(); ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1 chk("br_cyc2_lu_ignored", E_FLUSH);
        next(); #1 chk("br_done", E_NORM);

        // Branch during FLUSH reloads the counter.
        next(); branch_taken = 1'b1;
        #1 chk("rl_cyc1", E_FLUSH);
        next(); branch_taken = 1'b1;
        #1 chk("rl_cyc2", E_FLUSH);
        next(); #1 chk("rl_cyc3", E_FLUSH);
        next(); #1 chk("rl_done", E_NORM);

        // Memory busy during FLUSH freezes, then the remaining flush cycle runs.
        next(); branch_taken = 1'b1;
        #1 chk("mf_branch", E_FLUSH);
        for (int k = 0; k < 3; k++) begin
            next(); mem_busy = 1'b1;
            #1 chk($sformatf("mf_busy%0d", k), E_FREEZ);
        end
        next(); #1 chk("mf_rest_flush", E_FLUSH);
        next(); #1 chk("mf_done", E_NORM);

        // Timeout on the 4th consecutive busy cycle, sticky afterwards.
        for (int k = 1; k <= 6; k++) begin
            next(); mem_busy = 1'b1;
            #1 chk($sformatf("to_busy%0d", k), (k >= 4) ? 7'b0000001 : E_FREEZ);
        end
        next(); #1 chk("to_sticky", 7'b1100101);

        // Reset clears timeout; then HALT / resume.
        next(); reset = 1'b0;
        #1 chk("reset2", E_RST);
        next(); reset = 1'b1;
        id_halt = 1'b1;
        #1 chk("halt_req", E_NORM);
        next(); #1 chk("halted1", E_HALT);
        next(); branch_taken = 1'b1;
        #1 chk("halted_br_ignored", E_HALT);
        next(); resume = 1'b1; id_halt = 1'b1;
        #1 chk("halted_resume", E_HALT);
        next(); #1 chk("after_resume", E_NORM);

        // Reset asserted mid-halt takes effect immediately.
        next(); id_halt = 1'b1;
        #1 chk("halt_req2", E_NORM);
        next(); #1 chk("halted2", E_HALT);
        reset = 1'b0;
        #1 chk("reset_in_halt", E_RST);
        next(); reset = 1'b1;
        #1 chk("run_after_reset", E_NORM);

        next();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
